// File: rtl/fifo_stream_reader.sv
// Read-side engine for a registered-read FIFO: issues reads, captures returned words,
// and presents them through a 2-entry valid/ready buffer. Optional FIFO_READER_LAST_EN adds m_last framing.
module fifo_stream_reader #(
    parameter int DATAWIDTH  = 8,
    parameter int COUNTWIDTH = 16,
    parameter int PACKET_LEN = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read_req,
    input  logic [DATAWIDTH-1:0]  fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATAWIDTH-1:0]  m_data,
    output logic                  m_last,
    output logic [COUNTWIDTH-1:0] words_out,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    buf_state_t            state_reg;
    buf_state_t            state_next;
    logic                  inflight_reg;
    logic [COUNTWIDTH-1:0] words_out_reg;
    logic [DATAWIDTH-1:0]  buf_reg  [2];
    logic [DATAWIDTH-1:0]  buf_next [2];
    logic                  capture;
    logic                  transfer;
    logic [2:0]            occupancy_eff;

    assign capture   = inflight_reg;
    assign m_valid   = (state_reg != ST_EMPTY);
    assign transfer  = m_valid && m_ready;
    assign m_data    = buf_reg[0];
    assign words_out = words_out_reg;
    assign busy      = inflight_reg || m_valid;

    // A word leaving this cycle frees its slot, so the read pipe stays full under m_ready.
    always_comb begin
        occupancy_eff = 3'd0;
        case (state_reg)
            ST_ONE:  occupancy_eff = 3'd1;
            ST_TWO:  occupancy_eff = 3'd2;
            default: occupancy_eff = 3'd0;
        endcase
        if (transfer) begin
            occupancy_eff = occupancy_eff - 3'd1;
        end
    end

    assign fifo_read_req = enable && !fifo_empty && !reset
                         && ((occupancy_eff + {2'b00, inflight_reg}) < 3'd2);

    always_comb begin
        state_next  = state_reg;
        buf_next[0] = buf_reg[0];
        buf_next[1] = buf_reg[1];
        case (state_reg)
            ST_EMPTY: begin
                if (capture) begin
                    buf_next[0] = fifo_data;
                    state_next  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (capture && transfer) begin
                    buf_next[0] = fifo_data;
                end else if (capture) begin
                    buf_next[1] = fifo_data;
                    state_next  = ST_TWO;
                end else if (transfer) begin
                    state_next  = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (transfer) begin
                    buf_next[0] = buf_reg[1];
                    state_next  = ST_ONE;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_EMPTY;
            inflight_reg  <= 1'b0;
            words_out_reg <= '0;
            buf_reg[0]    <= '0;
            buf_reg[1]    <= '0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= fifo_read_req;
            buf_reg[0]   <= buf_next[0];
            buf_reg[1]   <= buf_next[1];
            if (transfer) begin
                words_out_reg <= words_out_reg + 1'b1;
            end
        end
    end

`ifdef FIFO_READER_LAST_EN
    localparam int BEAT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

    logic [BEAT_W-1:0] beat_reg;

    assign m_last = m_valid && (beat_reg == BEAT_W'(PACKET_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_reg <= '0;
        end else if (transfer) begin
            if (m_last) begin
                beat_reg <= '0;
            end else begin
                beat_reg <= beat_reg + 1'b1;
            end
        end
    end
`else
    // Evaluates to 0 for every legal PACKET_LEN; framing is absent in this build.
    localparam logic LAST_TIE = (PACKET_LEN < 1);

    assign m_last = LAST_TIE;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: behavioural registered-read FIFO, transfer monitor,
// and hand-computed expectations (COUNTWIDTH=4 so words_out wrap is exercised).
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic       fifo_read_req;
    logic [7:0] fifo_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [3:0] words_out;
    logic       busy;

    logic       force_empty = 1'b0;
    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         nreads = 0;
    int         underflows = 0;
    logic [7:0] rx_data [0:255];
    int         rx_cnt = 0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATAWIDTH (8),
        .COUNTWIDTH(4),
        .PACKET_LEN(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_read_req(fifo_read_req),
        .fifo_data    (fifo_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .words_out    (words_out),
        .busy         (busy)
    );

    assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

    // Registered-read FIFO model
    always @(posedge clk) begin
        if (fifo_read_req) begin
            fifo_data <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
            nreads    <= nreads + 1;
            if (fifo_empty) underflows <= underflows + 1;
        end
    end

    always @(posedge clk) begin
        if (!reset && m_valid && m_ready) begin
            rx_data[rx_cnt[7:0]] <= m_data;
            rx_cnt <= rx_cnt + 1;
            $display("xfer %0d data=0x%02h last=%0b words_out=%0d", rx_cnt, m_data, m_last, words_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    initial begin
        int r0;
        int b0;
        int first_c;
        int last_c;
        int nb;
        int beats;
        int stall_left;

        reset   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_words_out", words_out, 0);
        check("rst_busy", busy, 0);
        check("rst_read_req", fifo_read_req, 0);
        reset  = 1'b0;
        enable = 1'b1;
        tick();

        // Single word: read in cycle 0, valid in cycle 2
        r0 = nreads;
        push(8'hA5);
        #1;
        check("t1_req_c0", fifo_read_req, 1);
        tick();
        check("t1_req_c1", fifo_read_req, 0);
        check("t1_valid_c1", m_valid, 0);
        check("t1_busy_c1", busy, 1);
        tick();
        check("t1_valid_c2", m_valid, 1);
        check("t1_data", m_data, 8'hA5);
        check("t1_reads", nreads - r0, 1);
        m_ready = 1'b1;
        tick();
        check("t1_valid_after", m_valid, 0);
        check("t1_words_out", words_out, 1);
        check("t1_busy_after", busy, 0);

        // Streaming 0x00..0x0F with m_ready high; words_out wraps 15 -> 0 -> 1
        r0 = nreads;
        b0 = rx_cnt;
        first_c = -1;
        last_c  = -1;
        nb = 0;
        for (int i = 0; i < 16; i++) push(8'(i));
        for (int c = 0; c < 30; c++) begin
            #1;
            if (m_valid) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                nb++;
`ifndef FIFO_READER_LAST_EN
                check("t2_last_zero", m_last, 0);
`endif
            end
            tick();
        end
        check("t2_first_beat", first_c, 2);
        check("t2_last_beat", last_c, 17);
        check("t2_beats", nb, 16);
        check("t2_rx_count", rx_cnt - b0, 16);
        for (int i = 0; i < 16; i++) check("t2_data", rx_data[8'(b0 + i)], i);
        check("t2_words_out_wrap", words_out, 1);
        check("t2_reads", nreads - r0, 16);
        check("t2_busy_after", busy, 0);

        // Backpressure: 5 words, m_ready low -> exactly 2 reads
        m_ready = 1'b0;
        r0 = nreads;
        b0 = rx_cnt;
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        repeat (6) tick();
        check("t3_reads_held", nreads - r0, 2);
        check("t3_valid", m_valid, 1);
        check("t3_data_head", m_data, 8'h30);
        tick();
        check("t3_data_stable", m_data, 8'h30);
        check("t3_req_stopped", fifo_read_req, 0);
        m_ready = 1'b1;
        repeat (8) tick();
        check("t3_rx_count", rx_cnt - b0, 5);
        for (int i = 0; i < 5; i++) check("t3_data", rx_data[8'(b0 + i)], 8'h30 + i);
        check("t3_reads_total", nreads - r0, 5);
        check("t3_words_out", words_out, 6);
        check("t3_busy_after", busy, 0);

        // enable low blocks reads; forced empty drops the request the same cycle
        enable = 1'b0;
        r0 = nreads;
        b0 = rx_cnt;
        push(8'h40);
        push(8'h41);
        push(8'h42);
        #1;
        check("t4_req_disabled", fifo_read_req, 0);
        repeat (3) tick();
        check("t4_reads_disabled", nreads - r0, 0);
        check("t4_valid_disabled", m_valid, 0);
        enable = 1'b1;
        #1;
        check("t4_req_enabled", fifo_read_req, 1);
        tick();
        force_empty = 1'b1;
        #1;
        check("t4_req_forced", fifo_read_req, 0);
        repeat (4) tick();
        check("t4_reads_forced", nreads - r0, 1);
        check("t4_rx_forced", rx_cnt - b0, 1);
        check("t4_data_inflight", rx_data[8'(b0)], 8'h40);
        check("t4_busy_forced", busy, 0);
        force_empty = 1'b0;
        repeat (6) tick();
        check("t4_rx_count", rx_cnt - b0, 3);
        check("t4_data_last", rx_data[8'(b0 + 2)], 8'h42);
        check("t4_words_out", words_out, 9);

        // Reset while holding two words: they are discarded
        m_ready = 1'b0;
        r0 = nreads;
        for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
        repeat (5) tick();
        check("t5_reads_pre", nreads - r0, 2);
        check("t5_valid_pre", m_valid, 1);
        reset = 1'b1;
        tick();
        check("t5_valid_rst", m_valid, 0);
        check("t5_busy_rst", busy, 0);
        check("t5_words_rst", words_out, 0);
        check("t5_req_rst", fifo_read_req, 0);
        reset = 1'b0;
        b0 = rx_cnt;
        m_ready = 1'b1;
        repeat (8) tick();
        check("t5_rx_count", rx_cnt - b0, 2);
        check("t5_first_after_rst", rx_data[8'(b0)], 8'h52);
        check("t5_second_after_rst", rx_data[8'(b0 + 1)], 8'h53);
        check("t5_words_out", words_out, 2);

`ifdef FIFO_READER_LAST_EN
        // Packets of 4 beats; stall on beat 4 holds m_last
        reset = 1'b1;
        tick();
        reset = 1'b0;
        b0 = rx_cnt;
        beats = 0;
        stall_left = 2;
        for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
        for (int c = 0; c < 40; c++) begin
            if (beats < 8 && m_valid) begin
                if (beats == 3 && stall_left > 0) begin
                    m_ready = 1'b0;
                    #1;
                    check("t6_last_stalled", m_last, 1);
                    check("t6_data_stalled", m_data, 8'h63);
                    stall_left--;
                end else begin
                    m_ready = 1'b1;
                    #1;
                    check("t6_last", m_last, (beats % 4) == 3);
                    beats++;
                end
            end
            tick();
        end
        m_ready = 1'b1;
        check("t6_beats", beats, 8);
        check("t6_rx_count", rx_cnt - b0, 8);
        check("t6_final_data", rx_data[8'(b0 + 7)], 8'h67);
`endif

        check("underflow_none", underflows, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
